fnd_scan_controller: RTL and testbench

Time-multiplexed 4-digit 7-segment (FND) scan controller for the 100 MHz board clock. It uses an internal clock-enable tick rather than a derived clock. Each tick it steps to the next digit and blanks all outputs for an anti-ghosting interval. It then drives the decoded segments for the active digit. BCD input is latched once per frame to prevent tearing, and leading zeros can optionally be suppressed.

---
 rtl/fnd_scan_controller.sv | 154 +++++++++++++++
 tb/tb_fnd_scan_controller.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_controller.sv
// -----------------------------------------------------------------------------
// fnd_scan_controller
//
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment (FND)
// display. A free-running divider produces one clock-enable tick per digit
// slot. Each slot begins with an all-off anti-ghosting interval (BLANK),
// followed by the decoded segments of the active digit (SHOW). The BCD and
// decimal-point inputs are captured into shadow registers once per frame, so
// a value that changes mid-scan never tears across digits.
//
// Parameters:
//   TICK_DIV   clock cycles per digit slot (>= 4)
//   BLANK_CYC  all-off cycles at the start of each slot (1 .. TICK_DIV-2)
//   LZB        1 = blank leading zeros on digits 3..1, 0 = show every digit
//
// Ports:
//   i_clk    system clock
//   i_reset  synchronous, active-high reset
//   i_en     display enable; 0 forces every pin dark
//   i_bcd    four BCD nibbles, [3:0] = digit0 (rightmost) .. [15:12] = digit3
//   i_dp     decimal point per digit, 1 = lit
//   o_com    digit commons, active-low, one-hot-low while a digit is shown
//   o_seg    segments, active-low, {dp, g, f, e, d, c, b, a}
//   o_frame  one-cycle pulse on the cycle the shadow registers load
// -----------------------------------------------------------------------------
module fnd_scan_controller #(
   parameter int unsigned TICK_DIV  = 312500,
   parameter int unsigned BLANK_CYC = 1000,
   parameter bit          LZB       = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_en,
   input  logic [15:0] i_bcd,
   input  logic [3:0]  i_dp,
   output logic [3:0]  o_com,
   output logic [7:0]  o_seg,
   output logic        o_frame
);

   localparam int unsigned DIV_W = $clog2(TICK_DIV);
   localparam int unsigned BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   state_t             state_q;
   logic [DIV_W-1:0]   div_q;
   logic [BLK_W-1:0]   blk_q;
   logic [1:0]         digit_q;
   logic [15:0]        sh_bcd_q;
   logic [3:0]         sh_dp_q;
   logic               first_q;

   logic               tick;
   logic               load;
   logic [3:0]         nib;
   logic               lead_zero;
   logic [3:0]         com_d;
   logic [7:0]         seg_d;

   // Active-low segment pattern {g..a}; anything above 9 shows a lone '-'.
   function automatic logic [6:0] seg_decode(input logic [3:0] value);
      logic [6:0] pat;
      case (value)
         4'd0:    pat = 7'h40;
         4'd1:    pat = 7'h79;
         4'd2:    pat = 7'h24;
         4'd3:    pat = 7'h30;
         4'd4:    pat = 7'h19;
         4'd5:    pat = 7'h12;
         4'd6:    pat = 7'h02;
         4'd7:    pat = 7'h78;
         4'd8:    pat = 7'h00;
         4'd9:    pat = 7'h10;
         default: pat = 7'h3F;
      endcase
      return pat;
   endfunction

   assign tick = (div_q == DIV_W'(TICK_DIV - 1));
   // Shadow loads as digit0's slot begins, plus once right after reset so the
   // very first frame is not shown from the cleared shadow.
   assign load = first_q || (tick && (digit_q == 2'd3));

   // Next value of the output pins, driven from the current state and shadow.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      nib       = sh_bcd_q[{digit_q, 2'b00} +: 4];
      lead_zero = 1'b0;
      case (digit_q)
         2'd1:    lead_zero = (sh_bcd_q[15:4]  == 12'h000);
         2'd2:    lead_zero = (sh_bcd_q[15:8]  == 8'h00);
         2'd3:    lead_zero = (sh_bcd_q[15:12] == 4'h0);
         default: lead_zero = 1'b0;
      endcase

      com_d = ~(4'b0001 << digit_q);
      // A suppressed digit keeps its common low and its decimal point.
      seg_d = {~sh_dp_q[digit_q], (LZB && lead_zero) ? 7'h7F : seg_decode(nib)};

      if ((state_q != ST_SHOW) || !i_en) begin
         com_d = 4'hF;
         seg_d = 8'hFF;
      end
   end

   // NOTE: reset is sampled synchronously here; no asynchronous term appears in
   // the sensitivity list, so a reset mid-slot lands cleanly on the next edge.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         div_q    <= '0;
         digit_q  <= 2'd0;
         state_q  <= ST_BLANK;
         blk_q    <= '0;
         sh_bcd_q <= 16'h0000;
         sh_dp_q  <= 4'h0;
         first_q  <= 1'b1;
         o_com    <= 4'hF;
         o_seg    <= 8'hFF;
         o_frame  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every right-hand side
         // reads the pre-edge value regardless of statement order.
         div_q <= tick ? '0 : div_q + 1'b1;

         // A tick always wins over the BLANK exit and restarts the blank count.
         if (tick) begin
            digit_q <= digit_q + 2'd1;
            state_q <= ST_BLANK;
            blk_q   <= '0;
         end else if (state_q == ST_BLANK) begin
            blk_q <= blk_q + 1'b1;
            if (blk_q == BLK_W'(BLANK_CYC - 1)) begin
               state_q <= ST_SHOW;
            end
         end

         if (load) begin
            sh_bcd_q <= i_bcd;
            sh_dp_q  <= i_dp;
         end
         first_q <= 1'b0;

         o_frame <= load;
         o_com   <= com_d;
         o_seg   <= seg_d;
      end
   end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_fnd_scan_controller
//
// Three instances share one stimulus stream: (8,2,LZB=1), (8,2,LZB=0) and the
// boundary case (8,6,LZB=1). Each frame's input vector is pushed to a queue as
// it is driven; the frame record is popped when that frame's digit0 slot starts
// on the pins and every cycle of the frame is compared against it. Between
// shadow loads the inputs are scrambled to expose any tearing.
// -----------------------------------------------------------------------------
module tb_fnd_scan_controller;

   localparam int TD     = 8;   // TICK_DIV for all instances
   localparam int FRAME  = 4 * TD;
   localparam int NVEC   = 7;

   typedef struct packed {
      logic [15:0]     bcd;
      logic [3:0]      dp;
      logic [3:0][7:0] seg_lzb;  // expected o_seg per digit with LZB=1
      logic [3:0][7:0] seg_all;  // expected o_seg per digit with LZB=0
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] bcd;
   logic [3:0]  dp;
   logic [3:0]  com_a, com_b, com_c;
   logic [7:0]  seg_a, seg_b, seg_c;
   logic        frm_a, frm_b, frm_c;

   always #5 clk = ~clk;

   fnd_scan_controller #(.TICK_DIV(TD), .BLANK_CYC(2), .LZB(1'b1)) dut_a (
      .i_clk(clk), .i_reset(rst), .i_en(en), .i_bcd(bcd), .i_dp(dp),
      .o_com(com_a), .o_seg(seg_a), .o_frame(frm_a));

   fnd_scan_controller #(.TICK_DIV(TD), .BLANK_CYC(2), .LZB(1'b0)) dut_b (
      .i_clk(clk), .i_reset(rst), .i_en(en), .i_bcd(bcd), .i_dp(dp),
      .o_com(com_b), .o_seg(seg_b), .o_frame(frm_b));

   fnd_scan_controller #(.TICK_DIV(TD), .BLANK_CYC(TD - 2), .LZB(1'b1)) dut_c (
      .i_clk(clk), .i_reset(rst), .i_en(en), .i_bcd(bcd), .i_dp(dp),
      .o_com(com_c), .o_seg(seg_c), .o_frame(frm_c));

   int   checks;
   int   failures;
   int   n;          // rising edges since reset release
   vec_t vecs [NVEC];
   vec_t sb_q [$];
   vec_t cur;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s edge=%0d got=%h expected=%h", name, n, act, exp);
      end
   endtask

   // One clock, then compare all three instances against the frame record.
   task automatic step();
      logic       en_s;
      logic       rst_s;
      int         m;
      int         dv;
      int         dig;
      logic       show_ab;
      logic       show_c;
      logic [3:0] xcom;
      logic       xfrm;
      en_s  = en;
      rst_s = rst;
      @(posedge clk);
      #1;
      if (rst_s) begin
         n = 0;
         check("rst_com_a", 16'(com_a), 16'hF);
         check("rst_seg_a", 16'(seg_a), 16'hFF);
         check("rst_frm_a", 16'(frm_a), 16'h0);
         check("rst_com_c", 16'(com_c), 16'hF);
         check("rst_seg_b", 16'(seg_b), 16'hFF);
         return;
      end
      n++;
      m   = n - 1;
      dv  = m % TD;
      dig = (m / TD) % 4;
      if (m % FRAME == 0) begin
         check("sb_depth", 16'(sb_q.size()), 16'd1);
         if (sb_q.size() > 0) cur = sb_q.pop_front();
      end
      show_ab = en_s && (dv >= 2);
      show_c  = en_s && (dv >= TD - 2);
      xcom    = ~(4'b0001 << dig);
      xfrm    = (n == 1) || (n % FRAME == 0);
      check("com_a", 16'(com_a), show_ab ? 16'(xcom) : 16'hF);
      check("seg_a", 16'(seg_a), show_ab ? 16'(cur.seg_lzb[dig]) : 16'hFF);
      check("com_b", 16'(com_b), show_ab ? 16'(xcom) : 16'hF);
      check("seg_b", 16'(seg_b), show_ab ? 16'(cur.seg_all[dig]) : 16'hFF);
      check("com_c", 16'(com_c), show_c ? 16'(xcom) : 16'hF);
      check("seg_c", 16'(seg_c), show_c ? 16'(cur.seg_lzb[dig]) : 16'hFF);
      check("frm_a", 16'(frm_a), 16'(xfrm));
      check("frm_b", 16'(frm_b), 16'(xfrm));
      check("frm_c", 16'(frm_c), 16'(xfrm));
      check("onehot_c", 16'($countones(~com_c) <= 1), 16'd1);
   endtask

   initial begin
      // {bcd, dp, LZB=1 segs d3..d0, LZB=0 segs d3..d0}
      vecs[0] = '{16'h1234, 4'b0000, {8'hF9, 8'hA4, 8'hB0, 8'h99}, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
      vecs[1] = '{16'h0007, 4'b0100, {8'hFF, 8'h7F, 8'hFF, 8'hF8}, {8'hC0, 8'h40, 8'hC0, 8'hF8}};
      vecs[2] = '{16'h00A0, 4'b0000, {8'hFF, 8'hFF, 8'hBF, 8'hC0}, {8'hC0, 8'hC0, 8'hBF, 8'hC0}};
      vecs[3] = '{16'h5678, 4'b0001, {8'h92, 8'h82, 8'hF8, 8'h00}, {8'h92, 8'h82, 8'hF8, 8'h00}};
      vecs[4] = '{16'h0000, 4'b1000, {8'h7F, 8'hFF, 8'hFF, 8'hC0}, {8'h40, 8'hC0, 8'hC0, 8'hC0}};
      vecs[5] = '{16'h9F00, 4'b0000, {8'h90, 8'hBF, 8'hC0, 8'hC0}, {8'h90, 8'hBF, 8'hC0, 8'hC0}};
      vecs[6] = '{16'h0010, 4'b0000, {8'hFF, 8'hFF, 8'hF9, 8'hC0}, {8'hC0, 8'hC0, 8'hF9, 8'hC0}};

      checks   = 0;
      failures = 0;
      n        = 0;
      rst      = 1'b1;
      en       = 1'b1;
      bcd      = 16'h0000;
      dp       = 4'h0;
      cur      = vecs[0];
      repeat (3) step();

      // Table-driven frames: the vector must be stable on its load edge, then
      // the inputs are scrambled for the rest of the frame.
      for (int f = 0; f < NVEC; f++) begin
         bcd = vecs[f].bcd;
         dp  = vecs[f].dp;
         sb_q.push_back(vecs[f]);
         if (f == 0) rst = 1'b0;
         step();
         bcd = 16'($urandom);
         dp  = 4'($urandom);
         while (n < FRAME * (f + 1) - 1) begin
            // Enable dropped for 5 cycles inside digit2's SHOW of frame 2.
            if (n == 2 * FRAME + 18) en = 1'b0;
            if (n == 2 * FRAME + 23) en = 1'b1;
            step();
         end
      end

      // Reset asserted during digit2 SHOW: pins dark on the next edge and the
      // scan restarts at digit0 with a fresh first-frame load.
      bcd = vecs[0].bcd;
      dp  = vecs[0].dp;
      sb_q.push_back(vecs[0]);
      step();
      bcd = 16'($urandom);
      while (n < NVEC * FRAME + 2 * TD + 3) step();
      rst = 1'b1;
      step();
      step();
      sb_q.delete();
      bcd = vecs[3].bcd;
      dp  = vecs[3].dp;
      sb_q.push_back(vecs[3]);
      rst = 1'b0;
      step();
      bcd = 16'($urandom);
      dp  = 4'($urandom);
      while (n < 2 * TD + 4) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
